// File: rtl/sa_output_deskew.sv
// ----------------------------------------------------------------------------
// sa_output_deskew
//   Rebuilds whole output rows from the skewed column results of one
//   systolic array. Each column feeds its own small FIFO. A row is offered
//   downstream only when every column FIFO holds at least one entry, and all
//   columns pop together. The array cannot be stalled, so a result that
//   finds its column FIFO full (and no pop in the same cycle) is dropped and
//   a sticky per-column flag records the loss.
//
// Ports
//   clk           in   1      clock, rising edge
//   rst           in   1      synchronous active-high reset
//   col_data      in   N*W    per-column signed results, column j at [j*W +: W]
//   col_valid     in   N      per-column result strobes
//   out_data      out  N*W    head row, column j at [j*W +: W]
//   out_valid     out  1      a complete row is present on out_data
//   out_ready     in   1      downstream accepts the row
//   overflow      out  1      sticky: some column dropped a result
//   overflow_col  out  N      sticky per-column drop flags
// ----------------------------------------------------------------------------
module sa_output_deskew #(
  parameter int N     = 16,
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] col_data,
  input  logic [N-1:0]   col_valid,
  output logic [N*W-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           overflow,
  output logic [N-1:0]   overflow_col
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Storage and pointers. All columns pop together, so one read pointer
  // serves every column.
  logic [W-1:0]   mem_q    [N][DEPTH];
  logic [W-1:0]   mem_d    [N][DEPTH];
  logic [AW-1:0]  wr_ptr_q [N];
  logic [AW-1:0]  wr_ptr_d [N];
  logic [CW-1:0]  cnt_q    [N];
  logic [CW-1:0]  cnt_d    [N];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [N-1:0]   ovf_col_q, ovf_col_d;
  logic           ovf_q, ovf_d;
  logic [N*W-1:0] hold_q, hold_d;

  logic           pop_s;
  logic [N-1:0]   push_s;
  logic [N-1:0]   drop_s;
  logic [N*W-1:0] head_s;

  // Row availability, head row and the hold register that keeps out_data
  // steady while no complete row is present.
  always_comb begin
    out_valid = 1'b1;
    head_s    = '0;
    for (int j = 0; j < N; j++) begin
      if (cnt_q[j] == '0) begin
        out_valid = 1'b0;
      end else begin
        out_valid = out_valid;
      end
      head_s[j*W +: W] = mem_q[j][rd_ptr_q];
    end
    pop_s = out_valid & out_ready;
    if (out_valid) begin
      out_data = head_s;
    end else begin
      out_data = hold_q;
    end
    hold_d = out_data;
  end

  // Per-column accept/drop decision. A full column still accepts when the
  // row is popped in the same cycle, since that frees a slot.
  always_comb begin
    push_s = '0;
    drop_s = '0;
    for (int j = 0; j < N; j++) begin
      if (cnt_q[j] == FULL_CNT) begin
        push_s[j] = col_valid[j] & pop_s;
        drop_s[j] = col_valid[j] & ~pop_s;
      end else begin
        push_s[j] = col_valid[j];
        drop_s[j] = 1'b0;
      end
    end
  end

  // Next-state for storage, pointers, counts and sticky flags.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    ovf_col_d = ovf_col_q | drop_s;
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    for (int j = 0; j < N; j++) begin
      if (push_s[j]) begin
        mem_d[j][wr_ptr_q[j]] = col_data[j*W +: W];
        wr_ptr_d[j]           = wr_ptr_q[j] + AW'(1);
      end else begin
        wr_ptr_d[j] = wr_ptr_q[j];
      end
      case ({push_s[j], pop_s})
        2'b10:   cnt_d[j] = cnt_q[j] + CW'(1);
        2'b01:   cnt_d[j] = cnt_q[j] - CW'(1);
        default: cnt_d[j] = cnt_q[j];
      endcase
    end
    ovf_d = |ovf_col_d;
  end

  // Control state with synchronous reset; reset flushes every FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < N; j++) begin
        wr_ptr_q[j] <= '0;
        cnt_q[j]    <= '0;
      end
      rd_ptr_q  <= '0;
      ovf_col_q <= '0;
      ovf_q     <= 1'b0;
      hold_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_col_q <= ovf_col_d;
      ovf_q     <= ovf_d;
      hold_q    <= hold_d;
    end
  end

  // FIFO storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign overflow_col = ovf_col_q;
  assign overflow     = ovf_q;

endmodule
